// File: rtl/note_sequencer.sv
// Step sequencer that plays {dur, note} entries from a small write-only
// memory and hands the current note, gate and note-start strobe to a
// sine generator. Every output is a register.
//
// Handshake: i_start is a level that is acted on only in IDLE when i_stop is low.
// i_stop aborts from any non-IDLE state and wins over i_start.
// o_note_start and o_done are single-cycle pulses, and o_busy is high outside IDLE.
module note_sequencer #(
    parameter int TICK_DIV = 1000,
    parameter int GAP_CYC  = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop_en,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    output logic [3:0]        o_note,
    output logic              o_gate,
    output logic              o_note_start,
    output logic [ADDR_W-1:0] o_step,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = $clog2(TICK_DIV);
    localparam int GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0]     GAP_LAST  = GW'(GAP_CYC - 1);
    localparam logic [ADDR_W-1:0] STEP_LAST = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    logic [7:0]        r_mem [DEPTH];
    logic [7:0]        r_data;
    logic [3:0]        r_note;
    logic              r_gate;
    logic              r_note_start;
    logic [ADDR_W-1:0] r_step;
    logic              r_busy;
    logic              r_done;
    logic [3:0]        r_rem;
    logic [TW-1:0]     r_tick;
    logic [GW-1:0]     r_gap;

    state_t            w_state;
    logic [3:0]        w_note;
    logic              w_gate;
    logic              w_note_start;
    logic [ADDR_W-1:0] w_step;
    logic              w_done;
    logic [3:0]        w_rem;
    logic [TW-1:0]     w_tick;
    logic [GW-1:0]     w_gap;

    // Step memory: writes only while idle, never cleared; FETCH reads the current entry.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && !r_busy) r_mem[i_wr_addr] <= i_wr_data;
        if (r_state == S_FETCH) r_data <= r_mem[r_step];
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state;
    end

    // Next state, next outputs and next counter values.
    always_comb begin
        w_state      = r_state;
        w_note       = r_note;
        w_gate       = r_gate;
        w_note_start = 1'b0;
        w_step       = r_step;
        w_done       = 1'b0;
        w_rem        = r_rem;
        w_tick       = r_tick;
        w_gap        = r_gap;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    w_state = S_FETCH;
                    w_step  = '0;
                end
            end
            S_FETCH: w_state = S_LOAD;
            S_LOAD: begin
                if (r_data[7:4] != 4'd0) begin
                    w_note       = r_data[3:0];
                    w_rem        = r_data[7:4];
                    w_tick       = '0;
                    w_note_start = 1'b1;
                    w_gate       = (r_data[3:0] != 4'hF);
                    w_state      = S_PLAY;
                end else if (i_loop_en && (r_step != '0)) begin
                    // An empty step 0 never loops, so an empty sequence cannot spin.
                    w_step  = '0;
                    w_state = S_FETCH;
                end else begin
                    w_gate  = 1'b0;
                    w_done  = 1'b1;
                    w_state = S_DONE;
                end
            end
            S_PLAY: begin
                if (r_tick == TICK_LAST) begin
                    w_tick = '0;
                    if (r_rem == 4'd1) begin
                        w_gate  = 1'b0;
                        w_gap   = '0;
                        w_state = S_GAP;
                    end else begin
                        w_rem = r_rem - 4'd1;
                    end
                end else begin
                    w_tick = r_tick + 1'b1;
                end
            end
            S_GAP: begin
                w_gate = 1'b0;
                if (r_gap == GAP_LAST) begin
                    // Running off the last address acts like an end marker.
                    if (r_step == STEP_LAST) begin
                        if (i_loop_en) begin
                            w_step  = '0;
                            w_state = S_FETCH;
                        end else begin
                            w_done  = 1'b1;
                            w_state = S_DONE;
                        end
                    end else begin
                        w_step  = r_step + 1'b1;
                        w_state = S_FETCH;
                    end
                end else begin
                    w_gap = r_gap + 1'b1;
                end
            end
            S_DONE: w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
        if (i_stop && (r_state != S_IDLE)) begin
            w_state      = S_IDLE;
            w_gate       = 1'b0;
            w_note_start = 1'b0;
            w_done       = 1'b0;
        end
    end

    // Output and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_note       <= 4'd0;
            r_gate       <= 1'b0;
            r_note_start <= 1'b0;
            r_step       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rem        <= 4'd0;
            r_tick       <= '0;
            r_gap        <= '0;
        end else begin
            r_note       <= w_note;
            r_gate       <= w_gate;
            r_note_start <= w_note_start;
            r_step       <= w_step;
            r_busy       <= (w_state != S_IDLE);
            r_done       <= w_done;
            r_rem        <= w_rem;
            r_tick       <= w_tick;
            r_gap        <= w_gap;
        end
    end

    assign o_note       = r_note;
    assign o_gate       = r_gate;
    assign o_note_start = r_note_start;
    assign o_step       = r_step;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_state      = r_state;

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 1000, clk cycles per duration tick (>=2).
REQ-002 Parameter GAP_CYC, default 16, silent cycles between steps (>=1).
REQ-003 Parameter ADDR_W, default 4, step address width; DEPTH = 2^ADDR_W.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin playback from step 0; honoured only in IDLE.
REQ-007 stop  in  1  abort playback; priority over start.
REQ-008 loop_en  in  1  restart at step 0 at end of sequence instead of finishing.
REQ-009 wr_en  in  1  write strobe for step memory.
REQ-010 wr_addr  in  ADDR_W  step address written.
REQ-011 wr_data  in  8  {dur[7:4], note[3:0]}; dur in ticks, dur=0 is the end marker; note 0-11 chromatic, 15 = rest.
REQ-012 note  out  4  current note code for the sine generator.
REQ-013 gate  out  1  high while a non-rest note sounds.
REQ-014 note_start  out  1  one-cycle pulse when a step begins; drives sine generator phase reset.
REQ-015 step  out  ADDR_W  index of current step.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse on normal sequence completion.

Function
REQ-018 States SHALL be IDLE, FETCH, LOAD, PLAY, GAP, DONE; all outputs registered.
REQ-019 Memory SHALL be DEPTH x 8, written synchronously when wr_en=1 and busy=0; writes while busy are dropped; contents not cleared by reset.
REQ-020 IDLE: start=1 and stop=0 at edge E0 -> FETCH, step=0, busy=1 after E0.
REQ-021 FETCH: one cycle; registers mem[step] -> LOAD.
REQ-022 LOAD, dur!=0: latch note, remaining=dur, tick counter=0, note_start=1 for one cycle, gate=1 unless note=15 -> PLAY; gate/note_start visible after E2 of a start at E0.
REQ-023 LOAD, dur=0 at step!=0: loop_en=1 -> step=0, FETCH; loop_en=0 -> DONE.
REQ-024 LOAD, dur=0 at step=0 -> DONE regardless of loop_en (empty sequence, no infinite loop).
REQ-025 PLAY: tick counter counts 0..TICK_DIV-1 and wraps; at wrap remaining decrements; PLAY SHALL last exactly dur*TICK_DIV cycles, then GAP.
REQ-026 GAP: gate=0, note held, exactly GAP_CYC cycles; then step=step+1 -> FETCH.
REQ-027 GAP end with step=DEPTH-1: treated as end marker per REQ-023 (loop_en=1 -> step=0, FETCH; else DONE); step never wraps silently.
REQ-028 DONE: done=1 for exactly one cycle, gate=0, then IDLE.
REQ-029 stop=1 in any non-IDLE state: next state IDLE, gate=0, busy=0, note_start=0, no done pulse.
REQ-030 start while busy ignored; start and stop together in IDLE -> stay IDLE.
REQ-031 loop_en sampled only at end-of-sequence decisions.

Reset
REQ-032 reset=1 -> state IDLE, note=0, gate=0, note_start=0, step=0, busy=0, done=0, counters 0, from next edge.
REQ-033 reset mid-playback SHALL behave as REQ-032 with no done pulse; memory contents retained.

Verification (TICK_DIV=4, GAP_CYC=2, ADDR_W=4)
REQ-034 mem[0]=0x25, mem[1]=0x00, start -> note_start once, note=5, gate high 8 cycles, gate low 2 cycles, done pulse once, busy drops, total busy cycles match REQ-020..028.
REQ-035 mem[0]=0x1F, mem[1]=0x13, mem[2]=0x00 -> step 0 gate=0 for 4 cycles (rest), step 1 note=3 gate high 4 cycles, two note_start pulses, one done.
REQ-036 loop_en=1, mem[0]=0x12, mem[1]=0x00 -> note 2 repeats indefinitely, no done; assert stop mid-PLAY -> IDLE next cycle, gate=0, no done.
REQ-037 mem[0]=0x00, start with loop_en=1 -> DONE pulse within 3 cycles, no note_start.
REQ-038 All 16 entries dur=1 -> step 0..15 then DONE (loop_en=0) / step 0 again (loop_en=1); write during busy leaves memory unchanged.
REQ-039 reset asserted during GAP -> all outputs at REQ-032 values next cycle; subsequent start replays retained memory from step 0.
